// File: rtl/hex_debug_pager_if.sv
// Bundle between the system core / board pins and the hex debug pager.
// Latency: none (pure signal grouping).
// Backpressure: none; every signal is a free-running level or strobe.
interface hex_debug_pager_if #(
   parameter int NUM_DIGITS = 8,
   parameter int NUM_CHAN   = 4,
   parameter int CHAN_W     = 16
);
   logic [NUM_CHAN*CHAN_W-1:0]   chan_data;
   logic                         key_next;
   logic                         auto_en;
   logic                         freeze;
   logic [7*NUM_DIGITS-1:0]      hex_out;
   logic [$clog2(NUM_CHAN)-1:0]  chan_sel;
   logic                         key_pulse;

   // master drives the debug words and controls, slave is the pager itself
   modport master (
      output chan_data, key_next, auto_en, freeze,
      input  hex_out, chan_sel, key_pulse
   );

   modport slave (
      input  chan_data, key_next, auto_en, freeze,
      output hex_out, chan_sel, key_pulse
   );
endinterface

// File: rtl/hex_debug_pager.sv
// Pages NUM_CHAN debug words onto NUM_DIGITS active-low 7-seg digits (button / auto-scroll / freeze).
// Latency: chan_data -> hex_out 2 cycles; key_pulse -> new channel on hex_out 3 cycles.
// Backpressure: none; optional leading-zero blanking when HEX_PAGER_LZB_EN is defined.
// NUM_CHAN must be >= 2 and CHAN_W <= 4*NUM_DIGITS.
module hex_debug_pager #(
   parameter int NUM_DIGITS      = 8,
   parameter int NUM_CHAN        = 4,
   parameter int CHAN_W          = 16,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SCROLL_CYCLES   = 50000000
) (
   input  logic              clk,
   input  logic              resetn,
   hex_debug_pager_if.slave  bus
);

   localparam int CSW = $clog2(NUM_CHAN);
   localparam int NIB = (CHAN_W + 3) / 4;
   localparam int DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int SCW = $clog2(SCROLL_CYCLES);

   // active-low segment pattern, bit order g..a
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
         4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
         4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'ha: s = 7'h08;  4'hb: s = 7'h03;
         4'hc: s = 7'h46;  4'hd: s = 7'h21;  4'he: s = 7'h06;  default: s = 7'h0e;
      endcase
      return s;
   endfunction

   logic                   key_meta, key_sync, key_stable, key_pulse_q;
   logic [DBW-1:0]         deb_cnt;
   logic [SCW-1:0]         scroll_cnt;
   logic                   scroll_tick, advance;
   logic [CSW-1:0]         chan_sel_q;
   logic                   chan_changed;
   logic [CHAN_W-1:0]      chan_word, disp;
   logic                   disp_vld;
   logic [4*NIB-1:0]       ext;
   logic [NIB-1:0]         show;
   logic [6:0]             seg_nxt [NUM_DIGITS];
   logic [7*NUM_DIGITS-1:0] hex_q;

   // two-flop synchroniser for the asynchronous pushbutton; idles released (1)
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_meta <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         key_meta <= bus.key_next;
         key_sync <= key_meta;
      end
   end

   // accept a new key level only after it has differed from the stable level long enough
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         deb_cnt     <= '0;
         key_stable  <= 1'b1;
         key_pulse_q <= 1'b0;
      end else begin
         key_pulse_q <= 1'b0;
         if (key_sync == key_stable) begin
            deb_cnt <= '0;
         end else if (deb_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
            deb_cnt     <= '0;
            key_stable  <= key_sync;
            key_pulse_q <= ~key_sync;   // press only; release is silent
         end else begin
            deb_cnt <= deb_cnt + DBW'(1);
         end
      end
   end

   assign scroll_tick = bus.auto_en && (scroll_cnt == SCW'(SCROLL_CYCLES - 1));
   assign advance     = key_pulse_q | scroll_tick;

   // auto-scroll period counter; a manual press restarts the full period
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         scroll_cnt <= '0;
      end else if (!bus.auto_en || key_pulse_q || scroll_tick) begin
         scroll_cnt <= '0;
      end else begin
         scroll_cnt <= scroll_cnt + SCW'(1);
      end
   end

   // page counter; simultaneous press and tick still advance by one
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chan_sel_q   <= '0;
         chan_changed <= 1'b0;
      end else begin
         chan_changed <= advance;
         if (advance) begin
            chan_sel_q <= (chan_sel_q == CSW'(NUM_CHAN - 1)) ? '0 : chan_sel_q + CSW'(1);
         end
      end
   end

   // select the currently paged channel from the packed input
   always_comb begin
      chan_word = '0;
      for (int k = 0; k < NUM_CHAN; k++) begin
         if (chan_sel_q == CSW'(k)) chan_word = bus.chan_data[k*CHAN_W +: CHAN_W];
      end
   end

   // display register: track live data, or hold while frozen except one snapshot after a page change
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         disp     <= '0;
         disp_vld <= 1'b0;
      end else begin
         disp_vld <= 1'b1;
         if (!bus.freeze || chan_changed) disp <= chan_word;
      end
   end

   // zero-extend the partial top nibble and decide which nibbles are lit
   always_comb begin
      ext = '0;
      ext[CHAN_W-1:0] = disp;
   end

`ifdef HEX_PAGER_LZB_EN
   logic above;

   // light every nibble from the most significant non-zero one down; digit 0 is always lit
   always_comb begin
      show  = '0;
      above = 1'b0;
      for (int i = NIB - 1; i >= 0; i--) begin
         above   = above | (ext[4*i +: 4] != 4'h0);
         show[i] = above;
      end
      show[0] = 1'b1;
   end
`else
   // every nibble covered by the channel width is lit, leading zeros included
   always_comb begin
      show = '1;
   end
`endif

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      if (g < NIB) begin : g_live
         assign seg_nxt[g] = show[g] ? hex7(ext[4*g +: 4]) : 7'h7f;
      end else begin : g_blank
         assign seg_nxt[g] = 7'h7f;
      end
   end

   // registered decode; stays blank until the display register has loaded once after reset
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hex_q <= '1;
      end else if (disp_vld) begin
         for (int i = 0; i < NUM_DIGITS; i++) hex_q[7*i +: 7] <= seg_nxt[i];
      end
   end

   assign bus.hex_out   = hex_q;
   assign bus.chan_sel  = chan_sel_q;
   assign bus.key_pulse = key_pulse_q;

endmodule

// File: doc/hex_debug_pager.md
Name: hex_debug_pager

Overview:
- Parametrised successor to the board-level hard-wired hexdigit debug displays.
- Takes NUM_CHAN packed debug words (e.g. vga_x/vga_y, keycode, obs_mem, state) and shows one channel at a time on NUM_DIGITS seven-segment digits.
- Channel is paged by a debounced pushbutton or an optional auto-scroll timer; the displayed value can be frozen.
- Sits in the board top level between the system core and the HEX outputs.

Parameters:
- NUM_DIGITS, 8, number of seven-segment digits driven; digit 0 is least significant.
- NUM_CHAN, 4, number of debug channels; must be ≥2.
- CHAN_W, 16, width of each channel; must be ≤ 4*NUM_DIGITS.
- DEBOUNCE_CYCLES, 500000, clk cycles the key level must be stable to be accepted (10 ms @ 50 MHz).
- SCROLL_CYCLES, 50000000, auto-scroll period in clk cycles (1 s @ 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- resetn  in  1  asynchronous active-low reset.
- chan_data  in  NUM_CHAN*CHAN_W  packed channels; channel k is bits [k*CHAN_W +: CHAN_W].
- key_next  in  1  raw pushbutton, active-low, asynchronous to clk.
- auto_en  in  1  level; 1 enables auto-scroll.
- freeze  in  1  level; 1 holds the displayed value.
- hex_out  out  7*NUM_DIGITS  active-low segments; digit i is bits [7*i +: 7], bit order g..a as hexdigit.
- chan_sel  out  $clog2(NUM_CHAN)  currently displayed channel index.
- key_pulse  out  1  one-cycle strobe per accepted press.

Behaviour:
- Reset (resetn=0, async): chan_sel=0, key_pulse=0, hex_out all 7'h7f (blank), display register=0, debounce and scroll counters=0, stable key level=1 (released).
- Input sync: key_next passes through a 2-flop synchroniser before any use.
- Debounce:
  - Counter clears whenever the synchronised level equals the stable level.
  - Otherwise it increments; at DEBOUNCE_CYCLES-1 the stable level takes the synchronised value.
  - key_pulse=1 for exactly one cycle on a stable 1→0 transition. Release generates no pulse.
  - Bounces shorter than DEBOUNCE_CYCLES produce no pulse.
- Page counter:
  - Advance = key_pulse OR scroll_tick.
  - On advance: chan_sel = chan_sel+1, wrapping NUM_CHAN-1 → 0.
  - Simultaneous key_pulse and scroll_tick advance by exactly one.
- Auto-scroll:
  - When auto_en=1, the scroll counter increments each cycle; at SCROLL_CYCLES-1 it asserts scroll_tick for one cycle and clears.
  - auto_en=0 holds the counter at 0.
  - key_pulse also clears the counter, so the next auto step is a full period after a manual press.
- Display register:
  - freeze=0: loads the selected channel every cycle.
  - freeze=1: holds its value.
  - Exception: the cycle after chan_sel changes while frozen, it loads the new channel once (snapshot), then holds.
- Decode: each nibble maps to the standard active-low hex patterns 0–F. Digits at index ≥ ceil(CHAN_W/4) are driven 7'h7f. A partial top nibble is zero-extended.
- Latency: chan_data → hex_out is 2 cycles (display register + registered decode). key_pulse → new channel on hex_out is 3 cycles.
- Reset mid-operation: all state returns to reset values immediately. After release, the first update of hex_out is 2 cycles later.

Optional Feature:
- Macro HEX_PAGER_LZB_EN.
- Defined: leading-zero blanking.
  - Every digit above the most significant non-zero nibble is driven 7'h7f.
  - A value of 0 shows a single "0" on digit 0.
  - Latency is unchanged.
- Undefined: all ceil(CHAN_W/4) digits are shown, including leading zeros.

Test Plan:
- Bench parameters: NUM_DIGITS=4, NUM_CHAN=3, CHAN_W=12, DEBOUNCE_CYCLES=4, SCROLL_CYCLES=16.
- Reset and decode: hold resetn=0 → hex_out=28'hfffffff, chan_sel=0. Release with ch0=12'h1A3 → after 2 cycles digits 0..2 = 7'h30,7'h08,7'h79 and digit 3 = 7'h7f.
- Debounce: key_next low for 3 cycles then high → no key_pulse. Low for 10 cycles → exactly one key_pulse, chan_sel 0→1. Release → no pulse.
- Wrap and auto-scroll: auto_en=1, no key → chan_sel 0,1,2,0 at 16-cycle intervals. Key press accepted on the same cycle as scroll_tick → chan_sel advances by 1 only.
- Freeze snapshot: freeze=1 with ch0=12'h005, then change ch0 to 12'h777 → hex_out still shows 005. Press key → shows ch1's current value, which then stays held while ch1 changes.
- Mid-operation reset: assert resetn=0 while the debounce counter is at 2 and chan_sel=2 → next press needs a full 4 stable cycles, and chan_sel resumes from 0.
- HEX_PAGER_LZB_EN defined: ch0=12'h00F → digits 1..3 = 7'h7f, digit 0 = 7'h0e. ch0=0 → digit 0 = 7'h40, the rest blank.
